// File: rtl/mojolock_pkg.sv
// Shared widths and FSM state type for the ratio/normalising-divider front end.
package mojolock_pkg;

  localparam int unsigned ADC_W     = 16;
  localparam int unsigned SHIFT_W   = 4;
  localparam int unsigned LOG2N_MAX = 8;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

endpackage

// File: rtl/avg_accum.sv
// One-channel block averager: accumulator, sample counter, final-sample strobe and shift/clamp.
// Define RATIO_FRONTEND_ROUND_EN for round-half-up instead of truncation.
module avg_accum
  import mojolock_pkg::*;
#(
  parameter int unsigned LOG2N     = 4,
  parameter bit          CLAMP_NEG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ADC_W-1:0] din,
  output logic             last,
  output logic [ADC_W-1:0] avg
);

  localparam int unsigned AccW = ADC_W + LOG2N;
  localparam int unsigned CntW = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((1 << LOG2N) - 1);

  logic [CntW-1:0]        cnt_q;
  logic signed [AccW-1:0] acc_q;
  logic signed [AccW-1:0] sum;
  logic signed [AccW:0]   biased;
  logic signed [AccW:0]   res;

  assign last = in_valid && (cnt_q == CntMax);
  // Sum includes the current sample so the completing edge sees the whole block.
  assign sum  = acc_q + AccW'($signed(din));

`ifdef RATIO_FRONTEND_ROUND_EN
  localparam int Half = (LOG2N > 0) ? (1 << (LOG2N - 1)) : 0;
  assign biased = (AccW + 1)'(sum) + (AccW + 1)'(Half);
`else
  assign biased = (AccW + 1)'(sum);
`endif

  assign res = biased >>> LOG2N;

  always_comb begin
    avg = res[ADC_W-1:0];
    if (CLAMP_NEG && res[AccW]) begin
      avg = '0;
    end else if (res > (AccW + 1)'(32767)) begin
      avg = 16'h7FFF;
    end else if (res < (AccW + 1)'(-32768)) begin
      avg = 16'h8000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (in_valid) begin
      if (last) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
        acc_q <= sum;
      end
    end
  end

endmodule

// File: rtl/ratio_frontend.sv
// Block-averaging feeder for the normalising divider: issues averages with a start pulse,
// buffers one pending block while the divider is busy. Rounding via RATIO_FRONTEND_ROUND_EN.
module ratio_frontend
  import mojolock_pkg::*;
#(
  parameter int unsigned LOG2N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ADC_W-1:0]   ch0,
  input  logic [ADC_W-1:0]   ch1,
  input  logic [SHIFT_W-1:0] shift_in,
  input  logic               done,
  input  logic               clr_ovr,
  output logic               once,
  output logic [ADC_W-1:0]   out0,
  output logic [ADC_W-1:0]   out1,
  output logic [SHIFT_W-1:0] shift,
  output logic               busy,
  output logic               overrun
);

  logic             blk0, blk1, blk;
  logic [ADC_W-1:0] avg0, avg1;
  state_e           state_q;
  logic             pend_q;
  logic [ADC_W-1:0] pend0_q, pend1_q;

  avg_accum #(
    .LOG2N    (LOG2N),
    .CLAMP_NEG(1'b0)
  ) u_acc0 (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .din     (ch0),
    .last    (blk0),
    .avg     (avg0)
  );

  avg_accum #(
    .LOG2N    (LOG2N),
    .CLAMP_NEG(1'b1)
  ) u_acc1 (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .din     (ch1),
    .last    (blk1),
    .avg     (avg1)
  );

  assign blk = blk0 & blk1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      once    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      out0    <= '0;
      out1    <= '0;
      shift   <= '0;
      pend_q  <= 1'b0;
      pend0_q <= '0;
      pend1_q <= '0;
    end else begin
      once <= 1'b0;
      if (clr_ovr) overrun <= 1'b0;
      case (state_q)
        IDLE: begin
          if (blk) begin
            out0    <= avg0;
            out1    <= avg1;
            shift   <= shift_in;
            once    <= 1'b1;
            busy    <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // done is ignored during the start-pulse cycle itself.
          if (done && !once) begin
            if (blk) begin
              out0   <= avg0;
              out1   <= avg1;
              shift  <= shift_in;
              once   <= 1'b1;
              pend_q <= 1'b0;
            end else if (pend_q) begin
              out0   <= pend0_q;
              out1   <= pend1_q;
              shift  <= shift_in;
              once   <= 1'b1;
              pend_q <= 1'b0;
            end else begin
              busy    <= 1'b0;
              state_q <= IDLE;
            end
          end else if (blk) begin
            pend0_q <= avg0;
            pend1_q <= avg1;
            pend_q  <= 1'b1;
            if (pend_q) overrun <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ratio_frontend.sv
// Directed self-checking bench for ratio_frontend at LOG2N=2.
module tb_ratio_frontend;
  import mojolock_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [ADC_W-1:0]   ch0 = '0;
  logic [ADC_W-1:0]   ch1 = '0;
  logic [SHIFT_W-1:0] shift_in = '0;
  logic               done = 1'b0;
  logic               clr_ovr = 1'b0;
  logic               once;
  logic [ADC_W-1:0]   out0;
  logic [ADC_W-1:0]   out1;
  logic [SHIFT_W-1:0] shift;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int once_cnt = 0;

  ratio_frontend #(.LOG2N(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .ch0     (ch0),
    .ch1     (ch1),
    .shift_in(shift_in),
    .done    (done),
    .clr_ovr (clr_ovr),
    .once    (once),
    .out0    (out0),
    .out1    (out1),
    .shift   (shift),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (once === 1'b1) once_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c0, input logic [15:0] c1);
    in_valid = 1'b1;
    ch0 = c0;
    ch1 = c1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (once !== 1'b0) begin errors++; $display("FAIL reset_once got %0b want 0", once); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b want 0", overrun); end
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL reset_out0 got %h want 0000", out0); end
    checks++; if (out1 !== 16'h0000) begin errors++; $display("FAIL reset_out1 got %h want 0000", out1); end
    checks++; if (shift !== 4'h0) begin errors++; $display("FAIL reset_shift got %h want 0", shift); end
  endtask

  task automatic test_basic();
    shift_in = 4'd3;
    send(16'd100, 16'd4000);
    send(16'd200, 16'd4000);
    send(16'd300, 16'd4000);
    checks++; if (once !== 1'b0) begin errors++; $display("FAIL basic_early got %0b want 0", once); end
    send(16'd400, 16'd4000);
    checks++; if (once !== 1'b1) begin errors++; $display("FAIL basic_once got %0b want 1", once); end
    checks++; if (out0 !== 16'd250) begin errors++; $display("FAIL basic_out0 got %0d want 250", out0); end
    checks++; if (out1 !== 16'd4000) begin errors++; $display("FAIL basic_out1 got %0d want 4000", out1); end
    checks++; if (shift !== 4'd3) begin errors++; $display("FAIL basic_shift got %0d want 3", shift); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy); end
    shift_in = 4'd7;
    tick();
    checks++; if (once !== 1'b0) begin errors++; $display("FAIL basic_oncelen got %0b want 0", once); end
    checks++; if (shift !== 4'd3) begin errors++; $display("FAIL basic_hold got %0d want 3", shift); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busyhold got %0b want 1", busy); end
    pulse_done();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %0b want 0", busy); end
    shift_in = 4'd3;
  endtask

  task automatic test_neg_avg();
    logic [15:0] want;
`ifdef RATIO_FRONTEND_ROUND_EN
    want = 16'hFFFF;
`else
    want = 16'hFFFE;
`endif
    send(16'hFFFF, 16'd400);
    send(16'hFFFE, 16'd400);
    send(16'hFFFF, 16'd400);
    send(16'hFFFE, 16'd400);
    checks++; if (once !== 1'b1) begin errors++; $display("FAIL neg_once got %0b want 1", once); end
    checks++; if (out0 !== want) begin errors++; $display("FAIL neg_out0 got %h want %h", out0, want); end
    checks++; if (out1 !== 16'd400) begin errors++; $display("FAIL neg_out1 got %0d want 400", out1); end
    tick();
    pulse_done();
  endtask

  task automatic test_clamp();
    logic [15:0] m40;
    m40 = 16'hFFD8;
    for (int i = 0; i < 4; i++) send(m40, 16'hFFCE);
    checks++; if (once !== 1'b1) begin errors++; $display("FAIL clamp_once got %0b want 1", once); end
    checks++; if (out1 !== 16'h0000) begin errors++; $display("FAIL clamp_out1 got %h want 0000", out1); end
    checks++; if (out0 !== m40) begin errors++; $display("FAIL clamp_out0 got %h want %h", out0, m40); end
    tick();
    pulse_done();
  endtask

  task automatic test_overrun();
    int base;
    base = once_cnt;
    for (int i = 0; i < 4; i++) send(16'd10, 16'd1000);
    for (int i = 0; i < 4; i++) send(16'd20, 16'd2000);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %0b want 0", overrun); end
    for (int i = 0; i < 4; i++) send(16'd30, 16'd3000);
    tick();
    checks++; if (once_cnt - base !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", once_cnt - base); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", overrun); end
    checks++; if (out0 !== 16'd10) begin errors++; $display("FAIL ovr_hold got %0d want 10", out0); end
    pulse_done();
    checks++; if (once !== 1'b1) begin errors++; $display("FAIL ovr_reissue got %0b want 1", once); end
    checks++; if (out0 !== 16'd30) begin errors++; $display("FAIL ovr_out0 got %0d want 30", out0); end
    checks++; if (out1 !== 16'd3000) begin errors++; $display("FAIL ovr_out1 got %0d want 3000", out1); end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %0b want 0", overrun); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got %0b want 1", busy); end
    pulse_done();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_idle got %0b want 0", busy); end
  endtask

  task automatic test_simul_done();
    for (int i = 0; i < 4; i++) send(16'd5, 16'd50);
    for (int i = 0; i < 4; i++) send(16'd6, 16'd60);
    for (int i = 0; i < 3; i++) send(16'd9, 16'd90);
    done = 1'b1;
    send(16'd9, 16'd90);
    done = 1'b0;
    checks++; if (once !== 1'b1) begin errors++; $display("FAIL simul_once got %0b want 1", once); end
    checks++; if (out0 !== 16'd9) begin errors++; $display("FAIL simul_out0 got %0d want 9", out0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_ovr got %0b want 0", overrun); end
    tick();
    pulse_done();
    checks++; if (once !== 1'b0) begin errors++; $display("FAIL simul_stale got %0b want 0", once); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int base;
    send(16'd1000, 16'd1000);
    send(16'd1000, 16'd1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = once_cnt;
    tick();
    tick();
    checks++; if (once_cnt !== base) begin errors++; $display("FAIL rstmid_quiet got %0d want %0d", once_cnt, base); end
    send(16'd8, 16'd16);
    send(16'd8, 16'd16);
    checks++; if (once !== 1'b0) begin errors++; $display("FAIL rstmid_partial got %0b want 0", once); end
    send(16'd8, 16'd16);
    send(16'd8, 16'd16);
    checks++; if (once !== 1'b1) begin errors++; $display("FAIL rstmid_once got %0b want 1", once); end
    checks++; if (out0 !== 16'd8) begin errors++; $display("FAIL rstmid_out0 got %0d want 8", out0); end
    checks++; if (out1 !== 16'd16) begin errors++; $display("FAIL rstmid_out1 got %0d want 16", out1); end
    tick();
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_avg();
    test_clamp();
    test_overrun();
    test_simul_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ratio_frontend.md
Name: ratio_frontend

Overview:
- Upstream feeder for the normalising divider in the lock-in/servo path.
- Block-averages two 16-bit ADC channels: ch0 is the error signal, ch1 is the intensity/denominator, over 2^LOG2N samples.
- Presents the averages plus a mode/shift code to the divider, issues a one-cycle start pulse, then waits for the divider's done before issuing again.
- Accumulation of the next block continues while the divider is busy.

Parameters:
- LOG2N, 4, log2 of samples per block; legal range 0..8; 0 = pass-through, one issue per sample.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ch0/ch1 carry a new sample this cycle
- ch0  in  16  signed sample, numerator channel
- ch1  in  16  signed sample, denominator channel
- shift_in  in  4  divider mode/shift code; sampled at issue
- done  in  1  divider finished, single-cycle pulse
- clr_ovr  in  1  clears overrun
- once  out  1  divider start, single-cycle pulse
- out0  out  16  averaged ch0 to divider in0
- out1  out  16  averaged ch1 to divider in1
- shift  out  4  latched shift_in to divider shift
- busy  out  1  high from the once cycle until done is accepted
- overrun  out  1  sticky: a completed block was dropped

Behaviour:
- Reset values: once=0, busy=0, overrun=0, out0=out1=0, shift=0.
  - Accumulators, sample counter and the pending flag also clear.
- Reset mid-operation: any block in progress or pending is discarded. No once is issued afterwards until a full new block completes.
- Accumulation:
  - Two signed (16+LOG2N)-bit accumulators.
  - A LOG2N-bit sample counter advances on each in_valid and wraps to 0 after 2^LOG2N-1.
- Block completion: the edge that accepts the final sample produces a result.
  - avg0 = acc0 >>> LOG2N, arithmetic shift, truncation toward -inf.
  - avg1 is computed the same way. A negative avg1 clamps to 16'h0000, because the denominator is a magnitude.
  - Accumulators restart with zero on the next accepted sample. No samples are lost across blocks.
- State IDLE: on block completion, out0/out1/shift register and once=1 for exactly the next cycle; go to WAIT.
  - Latency is 1 cycle from the final sample edge.
  - busy=1 from the once cycle onward.
- State WAIT: done is sampled only in WAIT, never in the once cycle.
  - On done=1, return to IDLE and clear busy the following cycle.
  - If a block is pending, issue it instead: once=1 the cycle after done, and stay busy.
- out0/out1/shift are held stable from the once cycle until the next issue.
- Block completes while in WAIT with nothing pending: store it as pending, at most one.
- Block completes while in WAIT with a block already pending:
  - Overwrite the pending block with the newer one.
  - Set overrun=1.
- Simultaneous done and block completion in WAIT:
  - The completing block is issued directly (once next cycle).
  - No overrun is raised; any older pending block is superseded, again without overrun.
- in_valid during the once cycle: the sample is accumulated normally.
- Overrun clears on clr_ovr or rst. If a set event and clr_ovr occur in the same cycle, the set wins.
- LOG2N=0: every valid sample completes a block; averaging is the identity, and the ch1 clamp still applies.

Optional Feature:
- Macro: RATIO_FRONTEND_ROUND_EN
- With the macro defined: 2^(LOG2N-1) is added to each accumulator before the shift (round-half-up), and the result saturates to 16'h7FFF. For LOG2N=0 no offset is added.
- Without the macro: plain truncating arithmetic shift.

Decomposition:
- Shared package mojolock_pkg holds:
  - ADC_W=16
  - SHIFT_W=4
  - LOG2N_MAX=8
  - the state enum {IDLE, WAIT}
- One natural sub-module, avg_accum: one channel's accumulator, shift, round/clamp logic and final-sample strobe.
  - Instantiated twice; the ch1 instance has clamp-negative enabled by parameter.
- Pending-block buffer and FSM stay in the top.

Test Plan:
- LOG2N=2; ch0=100,200,300,400; ch1=4000 x4; shift_in=3 → once pulses 1 cycle after the 4th sample; out0=250, out1=4000, shift=3; busy=1 until done.
- LOG2N=2; ch0=-1,-2,-1,-2 → out0=16'hFFFE. With RATIO_FRONTEND_ROUND_EN: out0=16'hFFFF.
- LOG2N=2; ch1=-50 x4 → out1=16'h0000; ch0 average still passes through signed.
- LOG2N=2; done held low; 12 samples fed → exactly one once pulse; overrun=1 after the 12th sample; out0 unchanged.
  - Then pulse done → once the next cycle with the block from samples 9-12.
  - clr_ovr → overrun=0.
- LOG2N=2; done asserted in the same cycle the next block completes → once the next cycle; overrun stays 0.
- LOG2N=2; rst after 2 samples of a block → no once; then 4 samples of ch0=8 → out0=8, proving the partial sum was discarded.
